// File: rtl/d_pipe_pkg.sv
// Shared defaults, legal parameter ranges and the count-width helper
// for the elastic register pipe.
package d_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int MIN_WIDTH = 1;
   localparam int MAX_WIDTH = 64;
   localparam int MIN_DEPTH = 1;
   localparam int MAX_DEPTH = 16;

   // Bits needed to hold an occupancy count in 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/d_register_pipe_if.sv
// Producer/consumer bundle for d_register_pipe: input handshake,
// output handshake, flush and occupancy count.
interface d_register_pipe_if
   import d_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CW = cnt_w(DEPTH);

   logic             flush;
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic             d_ready;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             q_ready;
   logic [CW-1:0]    count;

   // Environment side: drives words in, consumes words out.
   modport master (
      output flush, d, d_valid, q_ready,
      input  d_ready, q, q_valid, count
   );

   // Pipe side.
   modport slave (
      input  flush, d, d_valid, q_ready,
      output d_ready, q, q_valid, count
   );

endinterface

// File: rtl/d_stage.sv
// One pipe slot: WIDTH-bit data register with a valid flag. Clear wins
// over load and returns the slot to RESET_VAL so an empty head reads RESET_VAL.
module d_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_ld,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_d
);

   logic             r_vld;
   logic [WIDTH-1:0] r_d;

   // Slot register: synchronous clear, otherwise load on enable.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_vld <= 1'b0;
         r_d   <= RESET_VAL;
      end else if (i_ld) begin
         r_vld <= 1'b1;
         r_d   <= i_d;
      end
   end

   assign o_vld = r_vld;
   assign o_d   = r_d;

endmodule

// File: rtl/d_register_pipe.sv
// In-order elastic register pipe. Occupied slots are always packed at the
// head (slot 0): a pop shifts every slot down by one and a push writes the
// first free slot, so a word into an empty pipe reaches q after one edge
// whatever DEPTH is. q/q_valid/count come straight from flops; d_ready
// depends only on the registered count.
module d_register_pipe
   import d_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               DEPTH     = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   d_register_pipe_if.slave bus
);

   localparam int CW = cnt_w(DEPTH);

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("d_register_pipe: WIDTH %0d outside 1..64", WIDTH);
   end
   if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("d_register_pipe: DEPTH %0d outside 1..16", DEPTH);
   end

   logic [CW-1:0]                r_count;
   logic                         w_push;
   logic                         w_pop;
   logic [CW-1:0]                w_wr_idx;
   logic [DEPTH-1:0]             w_vld;
   logic [DEPTH-1:0]             w_nxt_vld;
   logic [DEPTH-1:0]             w_ld;
   logic [DEPTH-1:0]             w_clr;
   logic [DEPTH-1:0][WIDTH-1:0]  w_dat;
   logic [DEPTH-1:0][WIDTH-1:0]  w_nxt_dat;
   logic [DEPTH-1:0][WIDTH-1:0]  w_ld_dat;

   assign bus.d_ready = (r_count < CW'(DEPTH));
   assign w_push      = bus.d_valid & bus.d_ready;
   assign w_pop       = w_vld[0] & bus.q_ready;
   // After a pop everything moves down one, so the free slot does too.
   assign w_wr_idx    = r_count - CW'(w_pop);

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic w_tgt;

      if (i < DEPTH - 1) begin : g_mid
         assign w_nxt_vld[i] = w_vld[i+1];
         assign w_nxt_dat[i] = w_dat[i+1];
      end else begin : g_tail
         assign w_nxt_vld[i] = 1'b0;
         assign w_nxt_dat[i] = RESET_VAL;
      end

      assign w_tgt       = w_push && (w_wr_idx == CW'(i));
      assign w_ld[i]     = (w_pop & w_nxt_vld[i]) | w_tgt;
      assign w_ld_dat[i] = (w_pop & w_nxt_vld[i]) ? w_nxt_dat[i] : bus.d;
      // A slot whose content shifted out with nothing to replace it empties.
      assign w_clr[i]    = rst | bus.flush | (w_pop & ~w_nxt_vld[i] & ~w_tgt);

      d_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk   (clk),
         .i_clr (w_clr[i]),
         .i_ld  (w_ld[i]),
         .i_d   (w_ld_dat[i]),
         .o_vld (w_vld[i]),
         .o_d   (w_dat[i])
      );
   end

   // Occupancy: reset/flush empty it, otherwise +push -pop.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.q       = w_dat[0];
   assign bus.q_valid = w_vld[0];
   assign bus.count   = r_count;

endmodule
